// File: rtl/agc_pkg.sv
`timescale 1ns/1ps
// Shared AGC definitions: gain index width/range and controller FSM encoding.
// The mapping stage imports the same gain constants.
package agc_pkg;

    localparam int AGC_GAIN_W   = 6;
    localparam int AGC_GAIN_MAX = 38;

    typedef logic [AGC_GAIN_W-1:0] agc_gain_t;

    localparam int AGC_STATE_W = 2;
    typedef logic [AGC_STATE_W-1:0] agc_state_t;

    localparam agc_state_t AGC_ST_MEASURE = 2'd0;
    localparam agc_state_t AGC_ST_DECIDE  = 2'd1;
    localparam agc_state_t AGC_ST_SETTLE  = 2'd2;

endpackage

// File: rtl/agc_power_meter.sv
`timescale 1ns/1ps
// Window power meter: |sample| accumulation, clip counting and window framing.
// Accepted magnitudes pass through one capture register before they are summed,
// so window_done rises one cycle before the final sum is ready. The
// controller's MEASURE->DECIDE transition absorbs that cycle.
module agc_power_meter #(
    parameter int SAMPLE_W = 8,
    parameter int WIN_LOG2 = 5,
    parameter int CLIP_MAG = 120
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_enable,
    input  logic                i_clear,
    input  logic                i_sample_valid,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic [SAMPLE_W-1:0] o_mean,
    output logic [WIN_LOG2:0]   o_clips,
    output logic                o_window_done
);

    localparam int                  ACC_W       = SAMPLE_W + WIN_LOG2;
    localparam logic [SAMPLE_W-1:0] LP_CLIP_MAG = SAMPLE_W'(CLIP_MAG);

    logic [SAMPLE_W-1:0] w_abs;
    logic                w_accept;

    logic [SAMPLE_W-1:0] r_abs;
    logic                r_abs_vld;
    logic [WIN_LOG2-1:0] r_count;
    logic                r_last;
    logic [ACC_W-1:0]    r_acc;
    logic [WIN_LOG2:0]   r_clips;

    // Unsigned magnitude; the most negative code maps to 2**(SAMPLE_W-1) without saturation.
    assign w_abs    = i_sample[SAMPLE_W-1] ? (~i_sample + 1'b1) : i_sample;
    // Once the last sample of a window is taken, nothing more is accepted until cleared.
    assign w_accept = i_enable & i_sample_valid & ~r_last;

    // Capture accepted magnitudes and track the position within the window.
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_abs     <= '0;
            r_abs_vld <= 1'b0;
            r_count   <= '0;
            r_last    <= 1'b0;
        end else if (i_clear) begin
            r_abs     <= '0;
            r_abs_vld <= 1'b0;
            r_count   <= '0;
            r_last    <= 1'b0;
        end else begin
            r_abs_vld <= w_accept;
            if (w_accept) begin
                r_abs   <= w_abs;
                r_count <= r_count + 1'b1;
                if (&r_count) begin
                    r_last <= 1'b1;
                end
            end
        end
    end

    // Sum captured magnitudes and count clipping samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc   <= '0;
            r_clips <= '0;
        end else if (i_clear) begin
            r_acc   <= '0;
            r_clips <= '0;
        end else if (r_abs_vld) begin
            r_acc <= r_acc + ACC_W'(r_abs);
            if (r_abs >= LP_CLIP_MAG) begin
                r_clips <= r_clips + 1'b1;
            end
        end
    end

    assign o_mean        = r_acc[ACC_W-1:WIN_LOG2];
    assign o_clips       = r_clips;
    assign o_window_done = r_last;

endmodule

// File: rtl/agc_gain_controller.sv
`timescale 1ns/1ps
// Closed-loop AGC controller: per-window gain decision, settle wait and lock tracking.
// Measurement is delegated to agc_power_meter.
module agc_gain_controller
    import agc_pkg::*;
#(
    parameter int SAMPLE_W      = 8,
    parameter int WIN_LOG2      = 5,
    parameter int GAIN_MAX      = AGC_GAIN_MAX,
    parameter int GAIN_INIT     = 38,
    parameter int SETTLE_CYCLES = 16,
    parameter int CLIP_MAG      = 120,
    parameter int CLIP_LIMIT    = 4,
    parameter int STEP_COARSE   = 4,
    parameter int LOCK_WINDOWS  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sample_valid,
    input  logic [SAMPLE_W-1:0]   sample,
    input  logic [SAMPLE_W-1:0]   thresh_hi,
    input  logic [SAMPLE_W-1:0]   thresh_lo,
    input  logic                  freeze,
    output logic [AGC_GAIN_W-1:0] gain_array,
    output logic                  gain_update,
    output logic                  locked
);

    localparam int         LOCK_W    = $clog2(LOCK_WINDOWS + 1);
    localparam int         CLIP_W    = WIN_LOG2 + 1;
    localparam agc_gain_t  LP_GMAX   = AGC_GAIN_W'(GAIN_MAX);
    localparam agc_gain_t  LP_GINIT  = AGC_GAIN_W'(GAIN_INIT);
    localparam agc_gain_t  LP_STEP   = AGC_GAIN_W'(STEP_COARSE);
    localparam logic [CLIP_W-1:0] LP_CLIP_LIMIT = CLIP_W'(CLIP_LIMIT);
    localparam logic [LOCK_W-1:0] LP_LOCK       = LOCK_W'(LOCK_WINDOWS);
    localparam logic [7:0]        LP_SETTLE_END = 8'(SETTLE_CYCLES - 1);

    agc_state_t        r_state;
    agc_gain_t         r_gain;
    logic              r_update;
    logic              r_locked;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic [7:0]        r_settle_cnt;

    logic [SAMPLE_W-1:0] w_mean;
    logic [CLIP_W-1:0]   w_clips;
    logic                w_window_done;
    agc_gain_t           w_req_gain;
    logic                w_in_band;
    logic                w_saturated;
    logic                w_change;
    logic [LOCK_W-1:0]   w_lock_next;

    agc_power_meter #(
        .SAMPLE_W (SAMPLE_W),
        .WIN_LOG2 (WIN_LOG2),
        .CLIP_MAG (CLIP_MAG)
    ) u_meter (
        .clk            (clk),
        .resetn         (resetn),
        .i_enable       (r_state == AGC_ST_MEASURE),
        .i_clear        (r_state == AGC_ST_DECIDE),
        .i_sample_valid (sample_valid),
        .i_sample       (sample),
        .o_mean         (w_mean),
        .o_clips        (w_clips),
        .o_window_done  (w_window_done)
    );

    // Gain request from the finished window, in priority order; a request that
    // cannot move the gain because it is already at a rail is flagged as saturated.
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        w_req_gain  = r_gain;
        w_in_band   = 1'b0;
        w_saturated = 1'b0;
        if (!freeze) begin
            if (w_clips >= LP_CLIP_LIMIT) begin
                w_req_gain  = (r_gain > LP_STEP) ? (r_gain - LP_STEP) : '0;
                w_saturated = (r_gain == '0);
            end else if (w_mean > thresh_hi) begin
                if (r_gain == '0) w_saturated = 1'b1;
                else              w_req_gain  = r_gain - 1'b1;
            end else if (w_mean < thresh_lo) begin
                if (r_gain >= LP_GMAX) w_saturated = 1'b1;
                else                   w_req_gain  = r_gain + 1'b1;
            end else begin
                w_in_band = 1'b1;
            end
        end
    end

    assign w_change    = (w_req_gain != r_gain);
    assign w_lock_next = (r_lock_cnt < LP_LOCK) ? (r_lock_cnt + 1'b1) : r_lock_cnt;

    // Controller FSM: wait for a window, apply the decision, then sit out VGA settling.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= AGC_ST_MEASURE;
            r_gain       <= LP_GINIT;
            r_update     <= 1'b0;
            r_locked     <= 1'b0;
            r_lock_cnt   <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_update <= 1'b0;
            case (r_state)
                AGC_ST_MEASURE: begin
                    if (w_window_done) begin
                        r_state <= AGC_ST_DECIDE;
                    end
                end
                AGC_ST_DECIDE: begin
                    if (w_change) begin
                        r_gain       <= w_req_gain;
                        r_update     <= 1'b1;
                        r_locked     <= 1'b0;
                        r_lock_cnt   <= '0;
                        r_settle_cnt <= LP_SETTLE_END;
                        r_state      <= AGC_ST_SETTLE;
                    end else begin
                        r_state <= AGC_ST_MEASURE;
                        if (w_saturated) begin
                            r_locked   <= 1'b0;
                            r_lock_cnt <= '0;
                        end else if (w_in_band) begin
                            r_lock_cnt <= w_lock_next;
                            if (w_lock_next == LP_LOCK) begin
                                r_locked <= 1'b1;
                            end
                        end
                    end
                end
                AGC_ST_SETTLE: begin
                    if (r_settle_cnt == 8'd0) begin
                        r_state <= AGC_ST_MEASURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= AGC_ST_MEASURE;
                end
            endcase
        end
    end

    assign gain_array  = r_gain;
    assign gain_update = r_update;
    assign locked      = r_locked;

endmodule

// File: tb/tb_agc_gain_controller.sv
`timescale 1ns/1ps
// Self-checking bench for agc_gain_controller: randomized windows scored
// against a window-level behavioural model of the AGC loop.
module tb_agc_gain_controller;

    localparam int K_CONST = 0;   // every sample equals amp
    localparam int K_ALT   = 1;   // +127 / -128 alternating
    localparam int K_RAND  = 2;   // random sign, magnitude 0..amp

    localparam int WIN     = 32;
    localparam int SETTLE  = 16;
    localparam int GMAX    = 38;

    logic       clk          = 1'b0;
    logic       clk_en       = 1'b0;
    logic       resetn       = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample       = 8'd0;
    logic [7:0] thresh_hi    = 8'd64;
    logic [7:0] thresh_lo    = 8'd32;
    logic       freeze       = 1'b0;
    logic [5:0] gain_array;
    logic       gain_update;
    logic       locked;

    int n_checks = 0;
    int n_pass   = 0;

    // Window-level model state.
    int m_gain     = GMAX;
    int m_lock_cnt = 0;
    int m_locked   = 0;

    agc_gain_controller dut (
        .clk          (clk),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .sample       (sample),
        .thresh_hi    (thresh_hi),
        .thresh_lo    (thresh_lo),
        .freeze       (freeze),
        .gain_array   (gain_array),
        .gain_update  (gain_update),
        .locked       (locked)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        sample_valid = 1'b0;
        resetn = 1'b0;
        #2;
        check("rst_gain", {26'd0, gain_array}, GMAX);
        check("rst_upd", {31'd0, gain_update}, 0);
        check("rst_lock", {31'd0, locked}, 0);
        m_gain = GMAX;
        m_lock_cnt = 0;
        m_locked = 0;
        #1;
        resetn = 1'b1;
    endtask

    function automatic int gen_val(input int kind, input int idx, input int amp);
        int mag;
        int v;
        case (kind)
            K_CONST: v = amp;
            K_ALT:   v = (idx % 2 == 0) ? 127 : -128;
            default: begin
                mag = int'($urandom_range(amp, 0));
                v = ($urandom_range(1, 0) == 1) ? -mag : mag;
                if (v > 127) v = 127;
            end
        endcase
        return v;
    endfunction

    // Drive one full window (with random idle gaps), then score the decision
    // and, if the gain moved, the settle period, feeding junk samples that must be ignored.
    task automatic do_window(input int kind, input int amp, input bit frz);
        int sum = 0;
        int clips = 0;
        int n = 0;
        int v, a, mean, nxt, hi, lo;
        bit in_band, change;
        freeze = frz;
        while (n < WIN) begin
            if ($urandom_range(3, 0) == 0) begin
                sample_valid = 1'b0;
                sample = 8'($urandom);
            end else begin
                v = gen_val(kind, n, amp);
                a = (v < 0) ? -v : v;
                sum += a;
                if (a >= 120) clips++;
                n++;
                sample_valid = 1'b1;
                sample = 8'(v);
            end
            tick;
            check("upd_quiet", {31'd0, gain_update}, 0);
        end
        sample_valid = 1'b1;
        sample = 8'd127;
        tick;
        check("upd_early", {31'd0, gain_update}, 0);
        check("gain_early", {26'd0, gain_array}, m_gain);
        check("lock_early", {31'd0, locked}, m_locked);
        tick;
        mean = sum / WIN;
        hi = int'(thresh_hi);
        lo = int'(thresh_lo);
        nxt = m_gain;
        in_band = 1'b0;
        if (!frz) begin
            if (clips >= 4)      nxt = (m_gain - 4 < 0) ? 0 : m_gain - 4;
            else if (mean > hi)  nxt = (m_gain - 1 < 0) ? 0 : m_gain - 1;
            else if (mean < lo)  nxt = (m_gain + 1 > GMAX) ? GMAX : m_gain + 1;
            else                 in_band = 1'b1;
        end
        change = (nxt != m_gain);
        if (change) begin
            m_gain = nxt;
            m_lock_cnt = 0;
            m_locked = 0;
        end else if (in_band) begin
            if (m_lock_cnt < 4) m_lock_cnt++;
            if (m_lock_cnt >= 4) m_locked = 1;
        end else if (!frz) begin
            m_lock_cnt = 0;
            m_locked = 0;
        end
        check("gain_dec", {26'd0, gain_array}, m_gain);
        check("upd_dec", {31'd0, gain_update}, {31'd0, change});
        check("lock_dec", {31'd0, locked}, m_locked);
        check("gain_range", {31'd0, gain_array <= 6'd38}, 1);
        if (change) begin
            for (int i = 0; i < SETTLE; i++) begin
                tick;
                check("upd_settle", {31'd0, gain_update}, 0);
                check("gain_settle", {26'd0, gain_array}, m_gain);
            end
        end
        sample_valid = 1'b0;
        freeze = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset with the clock stopped.
        #1;
        do_reset;
        clk_en = 1'b1;
        repeat (3) tick;
        check("idle_gain", {26'd0, gain_array}, GMAX);
        check("idle_upd", {31'd0, gain_update}, 0);

        // Loud in-band-free window: single fine step down.
        do_window(K_CONST, 100, 1'b0);
        check("step_37", {26'd0, gain_array}, 37);

        // Clipping: coarse steps to the floor, then no further pulses.
        do_reset;
        for (int w = 0; w < 12; w++) do_window(K_ALT, 0, 1'b0);
        check("clip_floor", {26'd0, gain_array}, 0);

        // Quiet input at the top rail: saturated request, no pulse.
        do_reset;
        for (int w = 0; w < 3; w++) do_window(K_CONST, 10, 1'b0);
        check("quiet_gain", {26'd0, gain_array}, GMAX);
        check("quiet_lock", {31'd0, locked}, 0);

        // In band: lock after the 4th window, then lost on a gain change.
        do_reset;
        for (int w = 0; w < 5; w++) do_window(K_CONST, 48, 1'b0);
        check("lock_set", {31'd0, locked}, 1);
        do_window(K_CONST, 100, 1'b0);

        // Freeze holds the gain and the lock state.
        do_reset;
        do_window(K_CONST, 100, 1'b1);
        do_window(K_CONST, 100, 1'b1);
        check("frz_gain", {26'd0, gain_array}, GMAX);
        for (int w = 0; w < 4; w++) do_window(K_CONST, 48, 1'b0);
        do_window(K_CONST, 100, 1'b1);
        check("frz_lock", {31'd0, locked}, 1);

        // Misconfigured thresholds: priority order still applies.
        thresh_hi = 8'd20;
        thresh_lo = 8'd90;
        do_window(K_CONST, 48, 1'b0);
        do_window(K_CONST, 10, 1'b0);
        thresh_hi = 8'd64;
        thresh_lo = 8'd32;

        // Reset in the middle of a window discards the partial sum.
        do_reset;
        repeat (20) begin
            sample_valid = 1'b1;
            sample = 8'd100;
            tick;
            check("part_upd", {31'd0, gain_update}, 0);
        end
        do_reset;
        do_window(K_CONST, 100, 1'b0);

        // Randomized windows and thresholds.
        for (int w = 0; w < 30; w++) begin
            thresh_lo = 8'($urandom_range(60, 10));
            thresh_hi = 8'(int'(thresh_lo) + int'($urandom_range(50, 0)));
            do_window(($urandom_range(9, 0) == 0) ? K_ALT : K_RAND,
                      int'($urandom_range(128, 0)),
                      ($urandom_range(5, 0) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
